sram_axi_bridge: RTL

- Sits directly downstream of the cache top.
- Accepts the cache's two SRAM-like master ports (inst side and data side), arbitrates between them and converts the winner into single-beat AXI3 read or write transactions.
- One outstanding transaction in total; responses return to the originating port as a one-cycle data_ok pulse.

---
 rtl/sram_axi_bridge.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_axi_bridge.sv
// Bridges the cache's inst/data SRAM-like ports onto a single-beat AXI3 master.
// Data port has fixed priority; exactly one transaction is in flight at a time.
module sram_axi_bridge #(
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  // inst-side SRAM-like port
  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [31:0]     inst_addr,
  input  logic [31:0]     inst_wdata,
  output logic [31:0]     inst_rdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  // data-side SRAM-like port
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic [31:0]     data_rdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  // AR channel
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  // R channel
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AW channel
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  // W channel
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // B channel
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_port;        // 1 = data port, 0 = inst port
  logic [1:0]      r_size;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_aw_done;
  logic            r_w_done;
  logic [31:0]     r_inst_rdata;
  logic [31:0]     r_data_rdata;

  logic            w_grant;
  logic            w_req_wr;
  logic [1:0]      w_req_size;
  logic [31:0]     w_req_addr;
  logic [31:0]     w_req_wdata;
  logic [ID_W-1:0] w_id;
  logic            w_unused;

  // Response IDs and error codes carry no information with one transaction in flight.
  assign w_unused = ^{rid, rresp, rlast, bid, bresp};

  assign w_grant     = data_req | inst_req;
  assign w_req_wr    = data_req ? data_wr    : inst_wr;
  assign w_req_size  = data_req ? data_size  : inst_size;
  assign w_req_addr  = data_req ? data_addr  : inst_addr;
  assign w_req_wdata = data_req ? data_wdata : inst_wdata;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_next       = r_state;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (r_state)
      S_IDLE: begin
        data_addr_ok = data_req;
        inst_addr_ok = inst_req & ~data_req;
        if (w_grant) w_next = w_req_wr ? S_W : S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) w_next = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) w_next = S_DONE;
      end
      S_W: begin
        // AW and W retire independently; leave once both have handshaken.
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        if ((r_aw_done | awready) && (r_w_done | wready)) w_next = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) w_next = S_DONE;
      end
      S_DONE: begin
        inst_data_ok = ~r_port;
        data_data_ok = r_port;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_port       <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_rdata <= 32'd0;
      r_data_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_port    <= data_req;
            r_size    <= w_req_size;
            r_addr    <= w_req_addr;
            r_wdata   <= w_req_wdata;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_W: begin
          if (awvalid && awready) r_aw_done <= 1'b1;
          if (wvalid && wready)   r_w_done  <= 1'b1;
        end
        S_R: begin
          if (rvalid) begin
            if (r_port) r_data_rdata <= rdata;
            else        r_inst_rdata <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_size)
      2'd0:    wstrb = 4'b0001 << r_addr[1:0];
      2'd1:    wstrb = 4'b0011 << r_addr[1:0];
      default: wstrb = 4'b1111;
    endcase
  end

  assign w_id       = ID_W'(r_port);
  assign arid       = w_id;
  assign awid       = w_id;
  assign wid        = w_id;
  assign araddr     = r_addr;
  assign awaddr     = r_addr;
  assign arsize     = {1'b0, r_size};
  assign awsize     = {1'b0, r_size};
  assign wdata      = r_wdata;
  assign wlast      = 1'b1;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;

  assign arlen   = 4'd0;
  assign arburst = 2'd1;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awlen   = 4'd0;
  assign awburst = 2'd1;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

endmodule
